// File: rtl/rx_uart_fifo.sv
// rx_uart_fifo -- UART receiver with a first-word-fall-through receive FIFO.
//
// Deserialises an asynchronous serial line (LSB first, optional parity,
// one or two stop bits) using mid-bit sampling. A start bit is accepted only
// if the line is still low half a bit after the falling edge, so short
// glitches are ignored. Each received word is pushed into a small FIFO
// together with its framing and parity flags. A consumer drains the FIFO
// through a valid/ready handshake.
//
// Ports
//   clk           in   system clock, rising edge
//   rst_rx        in   asynchronous reset, active-high
//   in_serial_tx  in   asynchronous serial line, idles high
//   data_rx       out  data of the head FIFO entry (0 when the FIFO is empty)
//   frame_err     out  head entry saw a 0 stop bit
//   parity_err    out  head entry failed its parity check
//   rx_valid      out  FIFO is non-empty and the head fields are valid
//   rx_ready      in   consumer takes the head entry this cycle
//   fifo_count    out  number of words held in the FIFO
//   overrun       out  sticky; set when a word is dropped because the FIFO is full
//   clr_err       in   single-cycle pulse that clears overrun
module rx_uart_fifo #(
  parameter int CLKS_PER_BIT = 16,
  parameter int DATA_W       = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst_rx,
  input  logic                          in_serial_tx,
  output logic [DATA_W-1:0]             data_rx,
  output logic                          frame_err,
  output logic                          parity_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overrun,
  input  logic                          clr_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  // DATA_W is at least 5, so this width also covers the stop-bit index.
  localparam int BIT_W = $clog2(DATA_W);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CW    = PTR_W + 1;
  localparam int ENT_W = DATA_W + 2;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic             ODD       = 1'(PARITY_ODD);
  localparam logic [CW-1:0]    FULL_CNT  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  // ---------------- line synchroniser ----------------
  logic sync1_q, sync2_q;
  logic line;
  assign line = sync2_q;

  // ---------------- receiver state ----------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BIT_W-1:0]   bit_q, bit_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               perr_q, perr_d;
  logic               ferr_q, ferr_d;

  logic tick, data_sample, par_sample, stop_sample, push, frame_clr;
  logic [ENT_W-1:0] push_word;

  // State register
  always_ff @(posedge clk or posedge rst_rx) begin
    if (rst_rx) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (!line) state_d = S_START;
      // Half a bit in: still low means a real start bit, otherwise a glitch.
      S_START:  if (cnt_q == CNT_HALF) state_d = line ? S_IDLE : S_DATA;
      S_DATA:   if (cnt_q == CNT_LAST && bit_q == DATA_LAST)
                  state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (cnt_q == CNT_LAST) state_d = S_STOP;
      // A low final stop bit means a break; wait for the line to return high.
      S_STOP:   if (cnt_q == CNT_LAST && bit_q == STOP_LAST)
                  state_d = line ? S_IDLE : S_BREAK;
      S_BREAK:  if (line) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: sample strobes and FIFO push
  always_comb begin
    tick        = (cnt_q == CNT_LAST);
    data_sample = (state_q == S_DATA) && tick;
    par_sample  = (state_q == S_PARITY) && tick;
    stop_sample = (state_q == S_STOP) && tick;
    push        = stop_sample && (bit_q == STOP_LAST);
    frame_clr   = (state_q == S_IDLE);
  end

  // Datapath next values
  always_comb begin
    cnt_d   = (state_d != state_q || cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
    bit_d   = bit_q;
    if (state_d != state_q) begin
      bit_d = '0;
    end else if (data_sample || stop_sample) begin
      bit_d = bit_q + 1'b1;
    end
    shift_d = data_sample ? {line, shift_q[DATA_W-1:1]} : shift_q;
    perr_d  = perr_q;
    ferr_d  = ferr_q;
    if (frame_clr) begin
      perr_d = 1'b0;
      ferr_d = 1'b0;
    end else begin
      if (par_sample)  perr_d = ((^shift_q) ^ line) != ODD;
      if (stop_sample) ferr_d = ferr_q | ~line;
    end
    // The current stop sample is folded in directly so the pushed word
    // carries the error from the last stop bit too.
    push_word = {perr_q, ferr_q | ~line, shift_q};
  end

  always_ff @(posedge clk or posedge rst_rx) begin
    if (rst_rx) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      sync1_q <= in_serial_tx;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
    end
  end

  // ---------------- FIFO ----------------
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]    count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             pop, full, do_push, drop;
  logic [ENT_W-1:0] head;

  always_comb begin
    pop       = (count_q != '0) && rx_ready;
    full      = (count_q == FULL_CNT);
    // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
    do_push   = push && (!full || pop);
    drop      = push && full && !pop;
    wr_d      = wr_q + PTR_W'(do_push);
    rd_d      = rd_q + PTR_W'(pop);
    count_d   = count_q + CW'(do_push) - CW'(pop);
    overrun_d = drop ? 1'b1 : (clr_err ? 1'b0 : overrun_q);
  end

  always_ff @(posedge clk or posedge rst_rx) begin
    if (rst_rx) begin
      wr_q      <= '0;
      rd_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Storage carries no reset; stale entries are masked by the empty check.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_q] <= push_word;
  end

  assign head       = (count_q != '0) ? mem[rd_q] : '0;
  assign rx_valid   = (count_q != '0);
  assign data_rx    = head[DATA_W-1:0];
  assign frame_err  = head[DATA_W];
  assign parity_err = head[DATA_W+1];
  assign fifo_count = count_q;
  assign overrun    = overrun_q;

endmodule
